capture_controller: RTL and testbench
=====================================

// Module: capture_controller
// PURPOSE
//  Sequences one logic-analyzer capture around trigger_basic and the sample RAM.
//  - Latches the trigger config and pulses arm to the trigger.
//  - Streams valid samples into a circular buffer during pre-trigger.
//  - On run, records the trigger address and captures post_count further samples.
//  - Then raises done to the host controller.
// PARAMETERS
//  SAMPLE_WIDTH  8   channels per sample; matches trigger_basic
//  ADDR_WIDTH    12  sample buffer address width; depth = 2**ADDR_WIDTH
// PORTS
//  clock        in   1             system clock, all logic on posedge
//  reset_n      in   1             asynchronous active-low reset
//  start        in   1             host request to begin a capture (level sampled in IDLE)
//  abort        in   1             host cancel; highest priority
//  valid        in   1             sample strobe
//  dataIn       in   SAMPLE_WIDTH  current sample
//  trigRising   in   SAMPLE_WIDTH  rising-edge trigger select, latched on start
//  trigFalling  in   SAMPLE_WIDTH  falling-edge trigger select, latched on start
//  post_count   in   ADDR_WIDTH    samples to capture after trigger sample, latched on start
//  run          in   1             trigger-fired from trigger_basic
//  arm          out  1             one-cycle arm pulse to trigger_basic
//  cfgRising    out  SAMPLE_WIDTH  latched rising select, to trigger_basic
//  cfgFalling   out  SAMPLE_WIDTH  latched falling select, to trigger_basic
//  wr_en        out  1             buffer write enable
//  wr_addr      out  ADDR_WIDTH    buffer write address
//  wr_data      out  SAMPLE_WIDTH  buffer write data
//  trig_addr    out  ADDR_WIDTH    buffer address of trigger sample
//  wrapped      out  1             buffer wrapped at least once this capture
//  busy         out  1             high in any state except IDLE
//  done         out  1             one-cycle capture-complete pulse
// BEHAVIOUR
//  Reset (reset_n=0, async):
//   - state=IDLE; all outputs and internal registers 0.
//   - A reset mid-capture discards the capture silently; no done pulse.
//  Write path (combinational from registered state):
//   - wr_en = valid & (state==PRE | state==POST).
//   - wr_data = dataIn.
//   - wr_addr is a register; it increments by 1 after every wr_en cycle and
//     wraps modulo 2**ADDR_WIDTH. wrapped sets on the 2**N-1 -> 0 increment.
//  IDLE:
//   - start=1 latches trigRising/trigFalling into cfgRising/cfgFalling and latches post_count.
//   - Clears wr_addr, wrapped and trig_addr; goes to ARM.
//  ARM:
//   - arm=1 for exactly this one cycle; run is ignored; next state PRE.
//  PRE:
//   - On run=1, trig_addr <= wr_addr. If valid, the trigger-cycle sample is
//     written at that address.
//   - Then POST if the latched count != 0, else DONE.
//   - The down-counter loads the latched count.
//  POST:
//   - Each wr_en cycle decrements the counter. The write that takes it 1->0
//     moves to DONE the next cycle.
//   - run is ignored.
//  DONE:
//   - done=1 for one cycle; next state IDLE. Buffer contents and trig_addr hold
//     until the next start.
//  Latency: start -> arm = 1 cycle; last post write -> done = 1 cycle.
//  Simultaneous events:
//   - abort in any state wins: state -> IDLE next cycle; arm, wr_en and done forced 0.
//   - start while busy is ignored.
//   - start and abort together in IDLE: stay IDLE.
//  Boundaries:
//   - post_count >= depth-1 overwrites pre-trigger data; permitted, no error.
//   - valid=0 stalls all counting; no timeout.
//  busy = (state != IDLE); DONE counts as busy.
// TESTING
//  T1 reset: assert reset_n=0 mid-POST
//   -> state IDLE immediately; arm/wr_en/done/busy = 0; no done afterwards.
//  T2 basic: ADDR_WIDTH=4, post_count=3, valid every cycle, run after 5 PRE writes
//   -> trig_addr=5; writes at addr 5,6,7,8; done one cycle after addr 8 write.
//  T3 zero post: post_count=0, run with valid=1
//   -> single write at trig_addr; done 1 cycle after the DONE transition; wr_en=0 after.
//  T4 wrap: ADDR_WIDTH=4, 20 PRE writes before run
//   -> wrapped=1; trig_addr=4; wr_addr sequence 15 -> 0.
//  T5 stall/ignore: valid toggling 1010, start pulsed again during POST
//   -> counter decrements only on valid; second start has no effect; exactly one arm pulse.
//  T6 abort: abort=1 in PRE with run=1 same cycle
//   -> IDLE next cycle; trig_addr unchanged (0); no done pulse.

Source files
------------

// File: rtl/capture_controller.sv
// Capture sequencer for a logic analyzer: arms the trigger, fills a circular sample
// buffer before the trigger, then records a fixed number of post-trigger samples.
module capture_controller #(
    parameter int unsigned SAMPLE_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH   = 12
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    valid,
    input  logic [SAMPLE_WIDTH-1:0] dataIn,
    input  logic [SAMPLE_WIDTH-1:0] trigRising,
    input  logic [SAMPLE_WIDTH-1:0] trigFalling,
    input  logic [ADDR_WIDTH-1:0]   post_count,
    input  logic                    run,
    output logic                    arm,
    output logic [SAMPLE_WIDTH-1:0] cfgRising,
    output logic [SAMPLE_WIDTH-1:0] cfgFalling,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [SAMPLE_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0]   trig_addr,
    output logic                    wrapped,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StPre,
        StPost,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [SAMPLE_WIDTH-1:0] cfg_rising_q, cfg_rising_d;
    logic [SAMPLE_WIDTH-1:0] cfg_falling_q, cfg_falling_d;
    logic [ADDR_WIDTH-1:0]   post_q, post_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0]   trig_addr_q, trig_addr_d;
    logic                    wrapped_q, wrapped_d;
    logic                    write_phase;
    logic                    wr_en_int;

    // abort suppresses every strobe in the same cycle it is seen
    assign write_phase = (state_q == StPre) || (state_q == StPost);
    assign wr_en_int   = valid && write_phase && !abort;

    always_comb begin
        state_d       = state_q;
        cfg_rising_d  = cfg_rising_q;
        cfg_falling_d = cfg_falling_q;
        post_d        = post_q;
        cnt_d         = cnt_q;
        wr_addr_d     = wr_addr_q;
        trig_addr_d   = trig_addr_q;
        wrapped_d     = wrapped_q;

        if (wr_en_int) begin
            wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
            if (wr_addr_q == {ADDR_WIDTH{1'b1}}) begin
                wrapped_d = 1'b1;
            end
        end

        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cfg_rising_d  = trigRising;
                        cfg_falling_d = trigFalling;
                        post_d        = post_count;
                        wr_addr_d     = '0;
                        wrapped_d     = 1'b0;
                        trig_addr_d   = '0;
                        state_d       = StArm;
                    end
                end
                StArm: begin
                    state_d = StPre;
                end
                StPre: begin
                    if (run) begin
                        trig_addr_d = wr_addr_q;
                        cnt_d       = post_q;
                        state_d     = (post_q != '0) ? StPost : StDone;
                    end
                end
                StPost: begin
                    if (wr_en_int) begin
                        cnt_d = cnt_q - ADDR_WIDTH'(1);
                        if (cnt_q == ADDR_WIDTH'(1)) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            cfg_rising_q  <= '0;
            cfg_falling_q <= '0;
            post_q        <= '0;
            cnt_q         <= '0;
            wr_addr_q     <= '0;
            trig_addr_q   <= '0;
            wrapped_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_rising_q  <= cfg_rising_d;
            cfg_falling_q <= cfg_falling_d;
            post_q        <= post_d;
            cnt_q         <= cnt_d;
            wr_addr_q     <= wr_addr_d;
            trig_addr_q   <= trig_addr_d;
            wrapped_q     <= wrapped_d;
        end
    end

    assign arm        = (state_q == StArm) && !abort;
    assign done       = (state_q == StDone) && !abort;
    assign busy       = (state_q != StIdle);
    assign wr_en      = wr_en_int;
    assign wr_data    = dataIn;
    assign wr_addr    = wr_addr_q;
    assign trig_addr  = trig_addr_q;
    assign wrapped    = wrapped_q;
    assign cfgRising  = cfg_rising_q;
    assign cfgFalling = cfg_falling_q;

endmodule

// File: tb/tb_capture_controller.sv
// Randomised bench for capture_controller: the driver predicts every buffer write and
// done event into queues; an independent monitor checks them as the DUT produces them.
module tb_capture_controller;

    localparam int unsigned SW    = 8;
    localparam int unsigned AW    = 4;
    localparam int          DEPTH = 16;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic          valid;
    logic [SW-1:0] dataIn;
    logic [SW-1:0] trigRising;
    logic [SW-1:0] trigFalling;
    logic [AW-1:0] post_count;
    logic          run;
    logic          arm;
    logic [SW-1:0] cfgRising;
    logic [SW-1:0] cfgFalling;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [SW-1:0] wr_data;
    logic [AW-1:0] trig_addr;
    logic          wrapped;
    logic          busy;
    logic          done;

    capture_controller #(
        .SAMPLE_WIDTH(SW),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .valid      (valid),
        .dataIn     (dataIn),
        .trigRising (trigRising),
        .trigFalling(trigFalling),
        .post_count (post_count),
        .run        (run),
        .arm        (arm),
        .cfgRising  (cfgRising),
        .cfgFalling (cfgFalling),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .trig_addr  (trig_addr),
        .wrapped    (wrapped),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [SW-1:0] data;
    } wr_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] trig;
        logic          wrapped;
    } done_t;

    wr_t   wq[$];
    done_t dq[$];

    int total = 0;
    int bad = 0;
    int arm_cnt = 0;
    int exp_arms = 0;

    // reference model of the buffer pointer for the current capture
    int            m_addr;
    bit            m_wrapped;
    logic [SW-1:0] last_r;
    logic [SW-1:0] last_f;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // monitor: consumes predictions whenever the DUT strobes
    always @(negedge clock) begin : monitor
        wr_t   we;
        done_t de;
        if (reset_n) begin
            if (arm) arm_cnt++;
            if (wr_en) begin
                if (wq.size() == 0) begin
                    chk("write_unexpected", {31'b0, wr_en}, 32'd0);
                end else begin
                    we = wq.pop_front();
                    chk("wr_addr", {28'b0, wr_addr}, {28'b0, we.addr});
                    chk("wr_data", {24'b0, wr_data}, {24'b0, we.data});
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("done_unexpected", {31'b0, done}, 32'd0);
                end else begin
                    de = dq.pop_front();
                    chk("done_cycle", cyc, de.cyc);
                    chk("done_trig_addr", {28'b0, trig_addr}, {28'b0, de.trig});
                    chk("done_wrapped", {31'b0, wrapped}, {31'b0, de.wrapped});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_write(input logic [SW-1:0] d);
        wr_t e;
        e.addr = m_addr[AW-1:0];
        e.data = d;
        wq.push_back(e);
        if (m_addr == DEPTH - 1) m_wrapped = 1'b1;
        m_addr = (m_addr + 1) % DEPTH;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clock);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_arms"}, arm_cnt, exp_arms);
    endtask

    // One capture. reset_at >= 0 pulls reset after that many post-trigger writes.
    task automatic capture(input int pre_n, input int post_n, input bit toggle,
                           input bit trig_valid, input bit abort_pre, input int reset_at);
        logic [SW-1:0] r;
        logic [SW-1:0] f;
        int            n;
        bit            v;
        done_t         de;
        r = SW'($urandom);
        f = SW'($urandom);
        start = 1'b1;
        trigRising = r;
        trigFalling = f;
        post_count = AW'(post_n);
        valid = 1'b0;
        run = 1'b0;
        m_addr = 0;
        m_wrapped = 1'b0;
        last_r = r;
        last_f = f;
        exp_arms++;
        tick();
        // ARM cycle: inputs change, run and valid must be ignored
        start = 1'b0;
        trigRising = ~r;
        trigFalling = ~f;
        post_count = AW'($urandom);
        valid = 1'b1;
        run = 1'b1;
        dataIn = SW'($urandom);
        @(negedge clock);
        chk("cfgRising", {24'b0, cfgRising}, {24'b0, r});
        chk("cfgFalling", {24'b0, cfgFalling}, {24'b0, f});
        tick();
        run = 1'b0;
        n = 0;
        v = 1'b1;
        while (n < pre_n) begin
            valid = toggle ? v : 1'b1;
            dataIn = SW'($urandom);
            if (valid) begin
                push_write(dataIn);
                n++;
            end
            v = ~v;
            tick();
        end
        run = 1'b1;
        valid = trig_valid;
        dataIn = SW'($urandom);
        if (abort_pre) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            run = 1'b0;
            valid = 1'b1;
            check_idle("abort");
            chk("abort_trig_addr", {28'b0, trig_addr}, 32'd0);
            tick();
            check_idle("abort_hold");
            valid = 1'b0;
            return;
        end
        de.trig = AW'(m_addr);
        if (trig_valid) push_write(dataIn);
        if (post_n == 0) begin
            de.cyc = cyc + 1;
            de.wrapped = m_wrapped;
            dq.push_back(de);
            tick();
            run = 1'b0;
        end else begin
            tick();
            n = 0;
            v = 1'b0;
            while (n < post_n) begin
                valid = toggle ? v : 1'b1;
                run = 1'($urandom);
                start = toggle && (n == 1);
                dataIn = SW'($urandom);
                if (reset_at >= 0 && n == reset_at) begin
                    #2;
                    reset_n = 1'b0;
                    #1;
                    chk("rst_busy", {31'b0, busy}, 32'd0);
                    chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
                    chk("rst_arm", {31'b0, arm}, 32'd0);
                    chk("rst_done", {31'b0, done}, 32'd0);
                    chk("rst_trig_addr", {28'b0, trig_addr}, 32'd0);
                    chk("rst_wr_addr", {28'b0, wr_addr}, 32'd0);
                    chk("rst_cfgRising", {24'b0, cfgRising}, 32'd0);
                    valid = 1'b0;
                    start = 1'b0;
                    run = 1'b0;
                    tick();
                    tick();
                    reset_n = 1'b1;
                    for (int i = 0; i < 5; i++) tick();
                    check_idle("post_rst");
                    chk("post_rst_wq", wq.size(), 32'd0);
                    return;
                end
                if (valid) begin
                    push_write(dataIn);
                    n++;
                    if (n == post_n) begin
                        de.cyc = cyc + 1;
                        de.wrapped = m_wrapped;
                        dq.push_back(de);
                    end
                end
                v = ~v;
                tick();
            end
            start = 1'b0;
            run = 1'b0;
        end
        // DONE cycle: a valid sample must not be written
        valid = 1'b1;
        @(negedge clock);
        chk("busy_in_done", {31'b0, busy}, 32'd1);
        tick();
        valid = 1'b0;
        check_idle("end");
        chk("end_wq", wq.size(), 32'd0);
        chk("end_dq", dq.size(), 32'd0);
        chk("trig_hold", {28'b0, trig_addr}, {28'b0, de.trig});
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        valid = 1'b1;
        dataIn = '0;
        trigRising = '1;
        trigFalling = '1;
        post_count = '1;
        run = 1'b1;
        tick();
        tick();
        @(negedge clock);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_arm", {31'b0, arm}, 32'd0);
        chk("reset_wr_en", {31'b0, wr_en}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_wr_addr", {28'b0, wr_addr}, 32'd0);
        chk("reset_trig_addr", {28'b0, trig_addr}, 32'd0);
        chk("reset_wrapped", {31'b0, wrapped}, 32'd0);
        chk("reset_cfgFalling", {24'b0, cfgFalling}, 32'd0);
        valid = 1'b0;
        run = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        capture(5, 3, 1'b0, 1'b1, 1'b0, -1);    // basic
        capture(2, 0, 1'b0, 1'b1, 1'b0, -1);    // zero post
        capture(20, 2, 1'b0, 1'b1, 1'b0, -1);   // pre-trigger wrap
        capture(3, 4, 1'b1, 1'b1, 1'b0, -1);    // stalls and ignored start
        capture(3, 0, 1'b0, 1'b1, 1'b1, -1);    // abort with run

        // start together with abort in IDLE: nothing latched, no arm
        start = 1'b1;
        abort = 1'b1;
        trigRising = ~last_r;
        trigFalling = ~last_f;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_idle("start_abort");
        chk("start_abort_cfg", {24'b0, cfgRising}, {24'b0, last_r});

        capture(2, 10, 1'b0, 1'b1, 1'b0, 4);    // reset mid-POST
        capture(4, 2, 1'b0, 1'b0, 1'b0, -1);    // trigger on a stalled cycle
        capture(3, 15, 1'b0, 1'b1, 1'b0, -1);   // post overwrites pre-trigger data
        capture(0, 1, 1'b1, 1'b1, 1'b0, -1);

        for (int k = 0; k < 8; k++) begin
            capture(int'($urandom_range(0, 20)), int'($urandom_range(0, 15)),
                    1'($urandom), 1'($urandom), 1'b0, -1);
        end

        for (int i = 0; i < 3; i++) tick();
        chk("final_wq", wq.size(), 32'd0);
        chk("final_dq", dq.size(), 32'd0);
        chk("final_arms", arm_cnt, exp_arms);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
